// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the two-port data-memory arbiter.
//   arb_state_e : sequencer states (IDLE, ACCESS)
//   PORT_PIPE / PORT_AUX : port identifiers (pipeline load/store, aux master)
//   mem_req_t   : one latched memory request (we, addr, wdata)
//   STARVE_W    : width of the saturating starvation counter
//   sat_inc16   : saturating 16-bit increment used by the statistics counters
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_e;

    localparam logic PORT_PIPE = 1'b0;
    localparam logic PORT_AUX  = 1'b1;

    localparam int STARVE_W = 4;
    localparam logic [STARVE_W-1:0] STARVE_SAT = '1;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// One requester port of the data-memory arbiter.
//   valid, we, addr, wdata : request, driven by the requester (master)
//   ready                  : request accepted this cycle (combinational)
//   rsp_valid, rsp_rdata   : one-cycle response pulse and read data
//                            (rsp_rdata is 0 for writes)
// The arbiter uses the slave modport, requesters use the master modport.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if;

    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/dmem_arb_prio.sv
// -----------------------------------------------------------------------------
// dmem_arb_prio
// Grant selection for the two-port data-memory arbiter plus the starvation
// counter that lets the auxiliary port overtake the pipeline port.
//   clk, rst_n         : clock, asynchronous active-low reset
//   p0_valid, p1_valid : request valid per port
//   idle               : sequencer is in IDLE and may accept
//   grant0, grant1     : combinational one-hot grant (both 0 when not idle)
// Parameter STARVE_MAX: lost arbitration cycles before port 1 wins a tie.
// -----------------------------------------------------------------------------
module dmem_arb_prio
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic p0_valid,
    input  logic p1_valid,
    input  logic idle,
    output logic grant0,
    output logic grant1
);

    localparam logic [STARVE_W-1:0] STARVE_THR = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt_q;
    logic [STARVE_W-1:0] starve_cnt_d;
    logic                p1_wins;

    // Port 1 wins when it is alone, or when a tie happens after it has lost
    // STARVE_MAX consecutive arbitration rounds.
    assign p1_wins = p1_valid & (~p0_valid | (starve_cnt_q >= STARVE_THR));
    assign grant1  = idle & p1_wins;
    assign grant0  = idle & p0_valid & ~p1_wins;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        // Only arbitration cycles move the counter; it holds during ACCESS.
        if (idle) begin
            if (grant1 || !p1_valid) begin
                starve_cnt_d = '0;
            end else if (grant0 && (starve_cnt_q != STARVE_SAT)) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one data memory between the pipeline load/store port (p0) and an
// auxiliary master (p1). One request is accepted at a time; the memory
// controls are then held for MEM_LAT cycles and a registered one-cycle
// response is returned to the owning port in the cycle after the access.
//   clk, rst_n          : clock, asynchronous active-low reset
//   p0, p1              : requester ports (dmem_arbiter_if.slave)
//   pipe_stall          : p0 request pending but not accepted this cycle
//   mem_read, mem_write : dmem memread / memwrite (write held one cycle only)
//   mem_addr, mem_wd    : dmem address / write data (hold when idle)
//   mem_rd              : dmem read data
// Optional build macro DMEM_ARB_STATS_EN adds saturating 16-bit counters:
//   stat_grant0, stat_grant1 : accepts per port
//   stat_conflict            : IDLE cycles with both ports valid
// Parameters: MEM_LAT (1..15), STARVE_MAX (1..15).
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave p0,
    dmem_arbiter_if.slave p1,
    output logic          pipe_stall,
    output logic          mem_read,
    output logic          mem_write,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wd,
    input  logic [31:0]   mem_rd
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_grant0,
    output logic [15:0]   stat_grant1,
    output logic [15:0]   stat_conflict
`endif
);

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

    arb_state_e       state_q, state_d;
    mem_req_t         req_q, req_d;
    logic             owner_q, owner_d;
    logic [3:0]       lat_cnt_q, lat_cnt_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [1:0][31:0] rsp_rdata_q, rsp_rdata_d;

    logic             idle;
    logic             grant0;
    logic             grant1;
    logic             accept;
    mem_req_t         p0_req;
    mem_req_t         p1_req;

    assign idle   = (state_q == IDLE);
    assign accept = grant0 | grant1;
    assign p0_req = {p0.we, p0.addr, p0.wdata};
    assign p1_req = {p1.we, p1.addr, p1.wdata};

    dmem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk      (clk),
        .rst_n    (rst_n),
        .p0_valid (p0.valid),
        .p1_valid (p1.valid),
        .idle     (idle),
        .grant0   (grant0),
        .grant1   (grant1)
    );

    // Next-state and registered-output computation for the sequencer.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        owner_d     = owner_q;
        lat_cnt_d   = lat_cnt_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d     = grant1 ? PORT_AUX : PORT_PIPE;
                    req_d       = grant1 ? p1_req : p0_req;
                    lat_cnt_d   = LAT_INIT;
                    mem_read_d  = ~req_d.we;
                    // Write strobe only in the first ACCESS cycle so dmem
                    // sees exactly one write edge regardless of MEM_LAT.
                    mem_write_d = req_d.we;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (lat_cnt_q == 4'd0) begin
                    state_d              = IDLE;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d[owner_q] = req_q.we ? 32'd0 : mem_rd;
                end else begin
                    lat_cnt_d  = lat_cnt_q - 4'd1;
                    mem_read_d = ~req_q.we;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            owner_q     <= PORT_PIPE;
            lat_cnt_q   <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            owner_q     <= owner_d;
            lat_cnt_q   <= lat_cnt_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign p0.ready     = grant0;
    assign p1.ready     = grant1;
    assign p0.rsp_valid = rsp_valid_q[0];
    assign p1.rsp_valid = rsp_valid_q[1];
    assign p0.rsp_rdata = rsp_rdata_q[0];
    assign p1.rsp_rdata = rsp_rdata_q[1];
    assign pipe_stall   = p0.valid & ~grant0;

    // Address and write data come straight from the latched request, so they
    // keep their last values while idle.
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = req_q.addr;
    assign mem_wd    = req_q.wdata;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_grant0_q, stat_grant0_d;
    logic [15:0] stat_grant1_q, stat_grant1_d;
    logic [15:0] stat_conflict_q, stat_conflict_d;

    always_comb begin
        stat_grant0_d   = grant0 ? sat_inc16(stat_grant0_q) : stat_grant0_q;
        stat_grant1_d   = grant1 ? sat_inc16(stat_grant1_q) : stat_grant1_q;
        stat_conflict_d = (idle && p0.valid && p1.valid) ?
                          sat_inc16(stat_conflict_q) : stat_conflict_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grant0_q   <= '0;
            stat_grant1_q   <= '0;
            stat_conflict_q <= '0;
        end else begin
            stat_grant0_q   <= stat_grant0_d;
            stat_grant1_q   <= stat_grant1_d;
            stat_conflict_q <= stat_conflict_d;
        end
    end

    assign stat_grant0   = stat_grant0_q;
    assign stat_grant1   = stat_grant1_q;
    assign stat_conflict = stat_conflict_q;
`endif

endmodule
